// File: rtl/codifica_hamming_serial_pkg.sv
// Shared definitions for the Hamming(15,11) serial encoder.
// Holds the word sizes, the codeword bit indices of the four parity bits,
// the bit-counter reset value and the serializer FSM state type.
package codifica_hamming_serial_pkg;

    localparam int HAMMING_DADOS   = 11;
    localparam int HAMMING_PALAVRA = 15;

    // Codeword bit index of each parity bit (bit 14 = Hamming position 1)
    localparam int P1_IDX = 14;
    localparam int P2_IDX = 13;
    localparam int P4_IDX = 11;
    localparam int P8_IDX = 7;

    localparam int           CNT_W       = 4;
    localparam logic [3:0]   CNT_INICIAL = 4'(HAMMING_PALAVRA - 1);

    typedef enum logic {
        OCIOSO   = 1'b0,
        ENVIANDO = 1'b1
    } estado_t;

endpackage

// File: rtl/codifica_hamming_serial_gera_hamming.sv
// gera_hamming: purely combinational Hamming(15,11) encoder, even parity.
// Output bit 14 is Hamming position 1, bit 0 is position 15, so it can be
// fed directly to the matching 15->11 corrector.
module gera_hamming
    import codifica_hamming_serial_pkg::*;
(
    input  logic [HAMMING_DADOS-1:0]   dado,
    output logic [HAMMING_PALAVRA-1:0] palavra
);

    logic [HAMMING_PALAVRA-1:0] w_dados;

    // Scatter the data bits into the non-power-of-two positions
    always_comb begin
        w_dados       = '0;
        w_dados[12]   = dado[10];
        w_dados[10:8] = dado[9:7];
        w_dados[6:0]  = dado[6:0];
    end

    // Each parity bit makes its covered group XOR to zero
    always_comb begin
        palavra         = w_dados;
        palavra[P1_IDX] = ^{w_dados[12], w_dados[10], w_dados[8], w_dados[6],
                            w_dados[4],  w_dados[2],  w_dados[0]};
        palavra[P2_IDX] = ^{w_dados[12], w_dados[9],  w_dados[8], w_dados[5],
                            w_dados[4],  w_dados[1],  w_dados[0]};
        palavra[P4_IDX] = ^{w_dados[10], w_dados[9],  w_dados[8], w_dados[3],
                            w_dados[2],  w_dados[1],  w_dados[0]};
        palavra[P8_IDX] = ^{w_dados[6],  w_dados[5],  w_dados[4], w_dados[3],
                            w_dados[2],  w_dados[1],  w_dados[0]};
    end

endmodule

// File: rtl/codifica_hamming_serial.sv
// codifica_hamming_serial: accepts an 11-bit word (valid/ready), encodes it
// as a Hamming(15,11) codeword held in palavra, and shifts it out MSB first
// on a valid/ready serial stream. A new word can be taken on the same edge
// that consumes the last bit, so frames may run back to back.
// Optional build macro: HAMMING_ERROR_INJECT_EN adds err_pos, which flips
// codeword bit (15 - err_pos) before it is loaded (0 = no flip).
module codifica_hamming_serial
    import codifica_hamming_serial_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [HAMMING_DADOS-1:0]   dado,
    input  logic                       dado_valid,
    output logic                       dado_ready,
`ifdef HAMMING_ERROR_INJECT_EN
    input  logic [3:0]                 err_pos,
`endif
    output logic [HAMMING_PALAVRA-1:0] palavra,
    output logic                       tx_bit,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       tx_first,
    output logic                       tx_last
);

    estado_t                    r_estado;
    logic [CNT_W-1:0]           r_cnt;
    logic [HAMMING_PALAVRA-1:0] r_palavra;
    logic                       r_tx_bit;
    logic                       r_tx_valid;
    logic                       r_tx_first;
    logic                       r_tx_last;

    logic [HAMMING_PALAVRA-1:0] w_codigo;
    logic [HAMMING_PALAVRA-1:0] w_carga;
    logic                       w_aceita;
    estado_t                    w_estado_nxt;
    logic [CNT_W-1:0]           w_cnt_nxt;
    logic [HAMMING_PALAVRA-1:0] w_pal_nxt;
    logic                       w_envia_nxt;

    gera_hamming u_gera_hamming (
        .dado    (dado),
        .palavra (w_codigo)
    );

`ifdef HAMMING_ERROR_INJECT_EN
    logic [3:0]                 w_err_bit;
    logic [HAMMING_PALAVRA-1:0] w_mascara;
    assign w_err_bit = 4'd15 - err_pos;
    assign w_mascara = (err_pos != 4'd0) ? (15'd1 << w_err_bit) : '0;
    assign w_carga   = w_codigo ^ w_mascara;
`else
    assign w_carga   = w_codigo;
`endif

    // Ready when idle, or when the last bit is being consumed this cycle
    assign dado_ready = rst_n && ((r_estado == OCIOSO) || ((r_cnt == '0) && tx_ready));
    assign w_aceita   = dado_valid && dado_ready;

    // Next state: load on accept, count down only on a consumed bit
    always_comb begin
        w_estado_nxt = r_estado;
        w_cnt_nxt    = r_cnt;
        w_pal_nxt    = r_palavra;
        if (r_estado == OCIOSO) begin
            if (w_aceita) begin
                w_estado_nxt = ENVIANDO;
                w_cnt_nxt    = CNT_INICIAL;
                w_pal_nxt    = w_carga;
            end
        end else if (tx_ready) begin
            if (r_cnt == '0) begin
                if (w_aceita) begin
                    w_cnt_nxt = CNT_INICIAL;
                    w_pal_nxt = w_carga;
                end else begin
                    w_estado_nxt = OCIOSO;
                end
            end else begin
                w_cnt_nxt = r_cnt - 4'd1;
            end
        end
        w_envia_nxt = (w_estado_nxt == ENVIANDO);
    end

    // FSM state plus registered serial outputs derived from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado   <= OCIOSO;
            r_cnt      <= '0;
            r_palavra  <= '0;
            r_tx_bit   <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_first <= 1'b0;
            r_tx_last  <= 1'b0;
        end else begin
            r_estado   <= w_estado_nxt;
            r_cnt      <= w_cnt_nxt;
            r_palavra  <= w_pal_nxt;
            r_tx_bit   <= w_envia_nxt && w_pal_nxt[w_cnt_nxt];
            r_tx_valid <= w_envia_nxt;
            r_tx_first <= w_envia_nxt && (w_cnt_nxt == CNT_INICIAL);
            r_tx_last  <= w_envia_nxt && (w_cnt_nxt == '0);
        end
    end

    assign palavra  = r_palavra;
    assign tx_bit   = r_tx_bit;
    assign tx_valid = r_tx_valid;
    assign tx_first = r_tx_first;
    assign tx_last  = r_tx_last;

endmodule

// File: tb/tb_codifica_hamming_serial.sv
// Testbench for codifica_hamming_serial.
// A position-based Hamming model and a bit queue predict every output each
// cycle; directed vectors add literal expectations for codewords, frame
// timing, back-to-back frames, stalls and mid-frame reset.
// Build with HAMMING_ERROR_INJECT_EN defined to also exercise err_pos.
module tb_codifica_hamming_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] dado = '0;
    logic        dado_valid = 1'b0;
    logic        dado_ready;
    logic [14:0] palavra;
    logic        tx_bit;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        tx_first;
    logic        tx_last;
`ifdef HAMMING_ERROR_INJECT_EN
    logic [3:0]  err_pos = '0;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    codifica_hamming_serial dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dado       (dado),
        .dado_valid (dado_valid),
        .dado_ready (dado_ready),
`ifdef HAMMING_ERROR_INJECT_EN
        .err_pos    (err_pos),
`endif
        .palavra    (palavra),
        .tx_bit     (tx_bit),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_first   (tx_first),
        .tx_last    (tx_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Hamming(15,11) by position: data fills non-power-of-two positions in
    // order, parity at 2^i is the XOR of every position with bit i set.
    function automatic logic [14:0] encode(input logic [10:0] d, input logic [3:0] e);
        logic [15:1] pos;
        logic [14:0] cw;
        logic        par;
        int          k;
        pos = '0;
        k   = 10;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                pos[p] = d[k];
                k--;
            end
        end
        for (int b = 1; b <= 8; b = b * 2) begin
            par = 1'b0;
            for (int p = 1; p <= 15; p++)
                if ((p & b) != 0) par ^= pos[p];
            pos[b] = par;
        end
        for (int p = 1; p <= 15; p++) cw[15 - p] = pos[p];
        if (e != 4'd0) cw[15 - e] = ~cw[15 - e];
        return cw;
    endfunction

`ifdef HAMMING_ERROR_INJECT_EN
    // Reference single-error corrector: syndrome is the XOR of set positions
    function automatic logic [10:0] corrige(input logic [14:0] cw);
        logic [14:0] c;
        int          syn;
        logic [10:0] d;
        int          k;
        c   = cw;
        syn = 0;
        for (int p = 1; p <= 15; p++)
            if (c[15 - p]) syn ^= p;
        if (syn != 0) c[15 - syn] = ~c[15 - syn];
        k = 10;
        d = '0;
        for (int p = 1; p <= 15; p++) begin
            if ((p & (p - 1)) != 0) begin
                d[k] = c[15 - p];
                k--;
            end
        end
        return d;
    endfunction
`endif

    // Model: queue of bits still to be sent for the current frame
    logic        m_q[$];
    logic [14:0] m_pal = '0;

    always @(posedge clk or negedge rst_n) begin
        logic        rdy;
        logic [14:0] cw;
        logic [3:0]  e;
        if (!rst_n) begin
            m_q.delete();
            m_pal = '0;
        end else begin
`ifdef HAMMING_ERROR_INJECT_EN
            e = err_pos;
`else
            e = 4'd0;
`endif
            rdy = (m_q.size() == 0) || ((m_q.size() == 1) && tx_ready);
            if ((m_q.size() > 0) && tx_ready) void'(m_q.pop_front());
            if (rdy && dado_valid) begin
                cw    = encode(dado, e);
                m_pal = cw;
                for (int i = 14; i >= 0; i--) m_q.push_back(cw[i]);
            end
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge clk) begin
        logic e_valid;
        e_valid = (m_q.size() > 0);
        check("tx_valid", tx_valid, e_valid);
        if (e_valid) check("tx_bit", tx_bit, m_q[0]);
        else         check("tx_bit_idle", tx_bit, 1'b0);
        check("tx_first", tx_first, m_q.size() == 15);
        check("tx_last", tx_last, m_q.size() == 1);
        check("dado_ready", dado_ready,
              rst_n && ((m_q.size() == 0) || ((m_q.size() == 1) && tx_ready)));
        check("palavra", palavra, m_pal);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one word while the block is idle; returns after it is accepted
    task automatic send_word(input logic [10:0] d);
        dado       = d;
        dado_valid = 1'b1;
        tick();
        dado_valid = 1'b0;
    endtask

    // Consume one frame, optionally stalling at a given counter value
    task automatic run_frame(input int stall_cnt, input int stall_len,
                             output logic [14:0] bits, output int cycles, output int held);
        int consumed;
        int stalled;
        consumed = 0;
        stalled  = 0;
        bits     = '0;
        cycles   = 0;
        held     = 0;
        for (int c = 0; c < 100; c++) begin
            tx_ready = !((stall_cnt >= 0) && (consumed == 14 - stall_cnt) && (stalled < stall_len));
            @(negedge clk);
            cycles++;
            if (tx_valid && tx_ready) begin
                bits = {bits[13:0], tx_bit};
                consumed++;
            end else if (!tx_ready) begin
                stalled++;
                if (tx_valid && (tx_bit == m_pal[7])) held++;
            end
            tick();
            if (consumed == 15) break;
        end
        tx_ready = 1'b1;
        check("frame_done", consumed, 15);
    endtask

    logic [10:0] vec_d [4] = '{11'h000, 11'h7FF, 11'h400, 11'h001};
    logic [14:0] vec_p [4] = '{15'h0000, 15'h7FFF, 15'h7000, 15'h6881};

    initial begin
        logic [14:0] bits, b1, b2;
        int          cyc, held, nval, first2, last1;

        // Reset state
        repeat (2) tick();
        check("rst_palavra", palavra, 15'h0000);
        check("rst_ready", dado_ready, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        rst_n = 1'b1;
        tick();
        check("ready_idle", dado_ready, 1'b1);

        // Pin the model against hand-computed codewords
        check("model_001", encode(11'h001, 4'd0), 15'h6881);
        check("model_400", encode(11'h400, 4'd0), 15'h7000);

        // Single frames with literal codewords and 15-cycle timing
        for (int i = 0; i < 4; i++) begin
            send_word(vec_d[i]);
            check("load_palavra", palavra, vec_p[i]);
            run_frame(-1, 0, bits, cyc, held);
            check("serial_bits", bits, vec_p[i]);
            check("frame_cycles", cyc, 15);
            check("palavra_held", palavra, vec_p[i]);
        end

        // Back-to-back frames: 30 consecutive valid cycles
        nval = 0; first2 = -1; last1 = -1; b1 = '0; b2 = '0;
        dado = 11'h400; dado_valid = 1'b1;
        tick();
        dado = 11'h7FF;
        for (int c = 0; c < 40; c++) begin
            logic drop;
            @(negedge clk);
            if (tx_valid) begin
                nval++;
                if (c < 15) b1 = {b1[13:0], tx_bit};
                else        b2 = {b2[13:0], tx_bit};
            end
            if (tx_first && (c > 0) && (first2 < 0)) first2 = c;
            if (tx_last && (last1 < 0)) last1 = c;
            drop = tx_last;
            tick();
            if (drop) dado_valid = 1'b0;
        end
        check("b2b_valid_cycles", nval, 30);
        check("b2b_first_last", last1, 14);
        check("b2b_second_first", first2, 15);
        check("b2b_frame1", b1, 15'h7000);
        check("b2b_frame2", b2, 15'h7FFF);

        // Stall of 5 cycles at counter 7
        send_word(11'h001);
        run_frame(7, 5, bits, cyc, held);
        check("stall_bits", bits, 15'h6881);
        check("stall_cycles", cyc, 20);
        check("stall_held", held, 5);

        // Reset asserted at counter 6 aborts the frame
        send_word(11'h2AB);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_tx_valid", tx_valid, 1'b0);
        check("abort_tx_bit", tx_bit, 1'b0);
        check("abort_first_last", {tx_first, tx_last}, 2'b00);
        check("abort_palavra", palavra, 15'h0000);
        check("abort_ready", dado_ready, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", dado_ready, 1'b1);
        tick();
        send_word(11'h001);
        run_frame(-1, 0, bits, cyc, held);
        check("post_rst_bits", bits, 15'h6881);
        check("post_rst_cycles", cyc, 15);

`ifdef HAMMING_ERROR_INJECT_EN
        // Injected error on position 15 and its correction
        err_pos = 4'd15;
        send_word(11'h001);
        err_pos = 4'd0;
        check("inject_palavra", palavra, 15'h6880);
        check("inject_corrige", corrige(palavra), 11'h001);
        run_frame(-1, 0, bits, cyc, held);
        check("inject_bits", bits, 15'h6880);
`endif

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/codifica_hamming_serial.md
CODIFICA_HAMMING_SERIAL -- requirements
Module: codifica_hamming_serial

Interface
REQ-001 SHALL have port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: dado  input  11  data word to encode, bit 10 = first data bit in the codeword.
REQ-004 SHALL have port: dado_valid  input  1  dado is offered this cycle.
REQ-005 SHALL have port: dado_ready  output  1  block accepts dado this cycle; transfer occurs when dado_valid && dado_ready.
REQ-006 SHALL have port: palavra  output  15  registered codeword; bit 14 = Hamming position 1, bit 0 = position 15.
REQ-007 SHALL have port: tx_bit  output  1  current serial codeword bit, MSB (bit 14) first.
REQ-008 SHALL have port: tx_valid  output  1  tx_bit is meaningful.
REQ-009 SHALL have port: tx_ready  input  1  downstream consumes tx_bit when tx_valid && tx_ready.
REQ-010 SHALL have port: tx_first  output  1  high with codeword bit 14; tx_last  output  1  high with codeword bit 0.

Function
REQ-011 Codeword SHALL place data: dado[10]->bit12, dado[9:7]->bits10:8, dado[6:0]->bits6:0.
REQ-012 Parity SHALL be even: bit14 = ^{12,10,8,6,4,2,0}; bit13 = ^{12,9,8,5,4,1,0}; bit11 = ^{10,9,8,3,2,1,0}; bit7 = ^{6,5,4,3,2,1,0}.
REQ-013 FSM SHALL have two states: OCIOSO (no codeword held) and ENVIANDO (serializing).
REQ-014 In OCIOSO dado_ready SHALL be 1; on accept, palavra SHALL load the codeword at that edge and state SHALL go to ENVIANDO with bit counter = 14.
REQ-015 In ENVIANDO tx_valid SHALL be 1 and tx_bit SHALL equal palavra[counter]; counter SHALL decrement only on a tx_valid && tx_ready cycle.
REQ-016 tx_bit, counter and palavra SHALL hold unchanged while tx_ready is 0 (stall of any length).
REQ-017 tx_first SHALL be high iff ENVIANDO and counter = 14; tx_last iff ENVIANDO and counter = 0.
REQ-018 dado_ready SHALL also be 1 in ENVIANDO when counter = 0 and tx_ready = 1, permitting back-to-back frames with no idle cycle.
REQ-019 On consuming bit 0: if dado_valid, load new codeword and restart at counter 14; else return to OCIOSO.
REQ-020 Latency: first serial bit SHALL be valid the cycle after acceptance; a frame SHALL take exactly 15 cycles with tx_ready held high.
REQ-021 palavra SHALL remain stable until the next accepted word.

Reset
REQ-022 While rst_n = 0: state OCIOSO, counter 0, palavra 0, tx_bit 0, tx_valid 0, tx_first 0, tx_last 0; dado_ready SHALL be 0 while rst_n = 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately; no partial-frame resumption after release.

Configuration
REQ-024 Macro HAMMING_ERROR_INJECT_EN SHALL, when defined, add input err_pos (4 bits), sampled with dado; nonzero k SHALL invert codeword bit (15-k) before loading palavra; 0 = no injection.
REQ-025 Without HAMMING_ERROR_INJECT_EN, err_pos SHALL not exist and palavra SHALL always be the clean codeword.

Structure
REQ-026 Shared package SHALL hold HAMMING_DADOS = 11, HAMMING_PALAVRA = 15, parity position indices, and the FSM state type.
REQ-027 Parity generation SHALL be a combinational sub-module gera_hamming (11 in, 15 out), reusable against the existing 15->11 corrector.

Verification
REQ-028 dado = 11'h000 -> palavra 15'h0000, 15 zero serial bits, tx_first then tx_last.
REQ-029 dado = 11'h7FF -> palavra 15'h7FFF; dado = 11'h400 -> 15'h7000; dado = 11'h001 -> 15'h6881, serial order bit14..bit0.
REQ-030 Two words offered back-to-back, tx_ready = 1 -> 30 consecutive tx_valid cycles, second tx_first right after first tx_last.
REQ-031 tx_ready low 5 cycles at counter 7 -> tx_bit held at palavra[7] for 5 cycles, frame completes in 20 cycles.
REQ-032 rst_n pulsed low at counter 6 -> all outputs 0 immediately; after release dado_ready = 1, next word sent from bit 14.
REQ-033 With HAMMING_ERROR_INJECT_EN, dado = 11'h001, err_pos = 15 -> palavra 15'h6880; corrector fed palavra returns 11'h001.
